// File: rtl/dbg_defs.sv
// Shared definitions for the register snapshot debug stage.
// Holds the FSM encoding, the snapshot geometry and the default trigger settings.
package dbg_defs;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_PC    = 3'd1,
    ST_HDR_INSTR = 3'd2,
    ST_SEL       = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int          SNAP_WORDS      = 34;
  localparam logic [31:0] DEF_BREAK_PC    = 32'h0000_0048;
  localparam int          DEF_CYCLE_LIMIT = 1000;
  localparam int          DEF_NUM_REGS    = 32;

  function automatic logic is_busy(input state_e s);
    return (s == ST_HDR_PC) || (s == ST_HDR_INSTR) || (s == ST_SEL) || (s == ST_SEND);
  endfunction

endpackage

// File: rtl/dbg_cycle_timer.sv
// Saturating watchdog counter: counts enabled cycles and raises expired_o
// once LIMIT-1 is reached, holding there rather than wrapping.
module dbg_cycle_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CNT_W = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_o = (count_q == LAST);

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_snapshot_streamer.sv
// Freezes the CPU on a trigger and streams PC, instr and r0..r31 over a
// valid/ready port; the register file is read through the reg_sel/reg_data tap.
module reg_snapshot_streamer
  import dbg_defs::*;
#(
  parameter logic [31:0] BREAK_PC    = DEF_BREAK_PC,
  parameter int          CYCLE_LIMIT = DEF_CYCLE_LIMIT,
  parameter int          NUM_REGS    = DEF_NUM_REGS,
  localparam int         SEL_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  input  logic             break_en_i,
  input  logic             start_i,
  output logic [SEL_W-1:0] reg_sel_o,
  input  logic [31:0]      reg_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic             out_last_o,
  output logic             halt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      data_q, data_d;
  logic             halt_q, halt_d;
  logic             timeout_q, timeout_d;

  logic wdog_fire;
  logic bp_hit;
  logic idle_trig;
  logic trigger;
  logic accept;
  logic last_idx;

  assign bp_hit    = break_en_i && (pc_i == BREAK_PC);
  assign idle_trig = (state_q == ST_IDLE) && (start_i || bp_hit || wdog_fire);
  // Only a manual pulse can restart from DONE; busy states ignore every source.
  assign trigger   = idle_trig || ((state_q == ST_DONE) && start_i);
  assign accept    = out_valid_o && out_ready_i;
  assign last_idx  = (idx_q == LAST_IDX);

  dbg_cycle_timer #(
    .LIMIT (CYCLE_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (trigger),
    .en_i      (state_q == ST_IDLE),
    .expired_o (wdog_fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (trigger) state_d = ST_HDR_PC;
      ST_HDR_PC:    if (accept)  state_d = ST_HDR_INSTR;
      ST_HDR_INSTR: if (accept)  state_d = ST_SEL;
      ST_SEL:                    state_d = ST_SEND;
      ST_SEND:      if (accept)  state_d = last_idx ? ST_DONE : ST_SEL;
      ST_DONE:      if (trigger) state_d = ST_HDR_PC;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    case (state_q)
      ST_HDR_PC: begin
        out_valid_o = 1'b1;
        out_data_o  = pc_q;
      end
      ST_HDR_INSTR: begin
        out_valid_o = 1'b1;
        out_data_o  = instr_q;
      end
      ST_SEND: begin
        out_valid_o = 1'b1;
        out_data_o  = data_q;
        out_last_o  = last_idx;
      end
      default: ;
    endcase
    reg_sel_o = idx_q;
    busy_o    = is_busy(state_q);
    done_o    = (state_q == ST_DONE);
    halt_o    = halt_q;
    timeout_o = timeout_q;
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    idx_d     = idx_q;
    data_d    = data_q;
    halt_d    = halt_q;
    timeout_d = timeout_q;
    if (trigger) begin
      pc_d      = pc_i;
      instr_d   = instr_i;
      idx_d     = '0;
      halt_d    = 1'b1;
      // Watchdog is reported only when nothing else asked for the snapshot.
      timeout_d = idle_trig && wdog_fire && !start_i && !bp_hit;
    end else if ((state_q == ST_SEND) && accept && !last_idx) begin
      idx_d = idx_q + 1'b1;
    end
    // r0 is architecturally zero, whatever the tap returns for index 0.
    if (state_q == ST_SEL) begin
      data_d = (idx_q == '0) ? '0 : reg_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      instr_q   <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
